// File: rtl/control_seq.sv
// control_seq: eight-phase VeriRISC instruction sequencer.
// Optional macro CONTROL_SEQ_RESUME_EN adds a resume input.

package typedefs;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

endpackage

module control_seq
  import typedefs::*;
(
  input  logic       clk,
  input  logic       rst,
`ifdef CONTROL_SEQ_RESUME_EN
  input  logic       resume,
`endif
  input  opcode_t    opcode,
  input  logic       zero,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       load_ir,
  output logic       load_ac,
  output logic       load_pc,
  output logic       inc_pc,
  output logic       halt,
  output logic       halted,
  output logic [2:0] phase
);

  phase_t     phase_q;
  phase_t     phase_d;
  logic       halted_q;
  logic       halted_d;
  logic       wake;
  logic [7:0] ph_oh;

  logic       op_alu;
  logic       op_hlt;
  logic       op_skz;
  logic       op_sto;
  logic       op_jmp;

`ifdef CONTROL_SEQ_RESUME_EN
  assign wake = resume;
`else
  assign wake = 1'b0;
`endif

  assign ph_oh  = 8'b1 << phase_q;
  assign phase  = phase_q;
  assign halted = halted_q;

  // Phase and halted state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Next phase: free-running wrap, parked at OP_FETCH while halted
  always_comb begin
    phase_d  = phase_t'(phase_q + 3'd1);
    halted_d = halted_q;
    if (halted_q) begin
      if (wake) begin
        halted_d = 1'b0;
        phase_d  = INST_ADDR;
      end else begin
        phase_d  = OP_FETCH;
      end
    end else if (phase_q == OP_ADDR && op_hlt) begin
      halted_d = 1'b1;
    end
  end

  // Opcode class decode
  always_comb begin
    op_alu = 1'b0;
    op_hlt = 1'b0;
    op_skz = 1'b0;
    op_sto = 1'b0;
    op_jmp = 1'b0;
    unique case (opcode)
      HLT:                op_hlt = 1'b1;
      SKZ:                op_skz = 1'b1;
      ADD, AND, XOR, LDA: op_alu = 1'b1;
      STO:                op_sto = 1'b1;
      JMP:                op_jmp = 1'b1;
    endcase
  end

  // Strobe decode per phase, forced low while halted
  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    load_ir = 1'b0;
    load_ac = 1'b0;
    load_pc = 1'b0;
    inc_pc  = 1'b0;
    halt    = 1'b0;
    if (!halted_q) begin
      unique case (1'b1)
        ph_oh[INST_ADDR]: begin
        end
        ph_oh[INST_FETCH]: begin
          mem_rd  = 1'b1;
        end
        ph_oh[INST_LOAD]: begin
          mem_rd  = 1'b1;
          load_ir = 1'b1;
        end
        ph_oh[IDLE]: begin
          mem_rd  = 1'b1;
          load_ir = 1'b1;
        end
        ph_oh[OP_ADDR]: begin
          inc_pc  = 1'b1;
          halt    = op_hlt;
        end
        ph_oh[OP_FETCH]: begin
          mem_rd  = op_alu;
        end
        ph_oh[ALU_OP]: begin
          mem_rd  = op_alu;
          load_ac = op_alu;
          inc_pc  = op_skz & zero;
          load_pc = op_jmp;
        end
        ph_oh[STORE]: begin
          mem_rd  = op_alu;
          load_ac = op_alu;
          inc_pc  = op_jmp;
          load_pc = op_jmp;
          mem_wr  = op_sto;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: scoreboard bench for control_seq.
// Build with CONTROL_SEQ_RESUME_EN to exercise resume.

module tb_control_seq;
  import typedefs::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       zero = 1'b0;
  logic       resume = 1'b0;
  opcode_t    opcode = ADD;
  logic       mem_rd, mem_wr, load_ir, load_ac;
  logic       load_pc, inc_pc, halt, halted;
  logic [2:0] phase;

  always #5 clk = ~clk;

  control_seq dut (
    .clk     (clk),
    .rst     (rst),
`ifdef CONTROL_SEQ_RESUME_EN
    .resume  (resume),
`endif
    .opcode  (opcode),
    .zero    (zero),
    .mem_rd  (mem_rd),
    .mem_wr  (mem_wr),
    .load_ir (load_ir),
    .load_ac (load_ac),
    .load_pc (load_pc),
    .inc_pc  (inc_pc),
    .halt    (halt),
    .halted  (halted),
    .phase   (phase)
  );

  typedef struct packed {
    logic [2:0] ph;
    logic       hltd;
    logic       hlt;
    logic       rd;
    logic       wr;
    logic       ir;
    logic       ac;
    logic       lpc;
    logic       ipc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_ph   = 0;
  bit   m_hltd = 1'b0;

  // Reference: strobes from the per-phase activity of each opcode
  function automatic exp_t expect_now(int ph, bit hd,
                                      opcode_t op, logic z);
    exp_t     e;
    bit       alu;
    bit [7:0] rdm;
    e = '0;
    e.ph = 3'(ph);
    e.hltd = hd;
    if (hd) return e;
    alu = op inside {ADD, AND, XOR, LDA};
    rdm = 8'b0000_1110 | (alu ? 8'b1110_0000 : 8'h00);
    e.rd  = rdm[ph];
    e.ir  = (ph == 2 || ph == 3);
    e.ac  = alu && (ph == 6 || ph == 7);
    e.lpc = (op == JMP) && (ph == 6 || ph == 7);
    e.ipc = (ph == 4) ||
            (ph == 6 && op == SKZ && z) ||
            (ph == 7 && op == JMP);
    e.wr  = (op == STO) && (ph == 7);
    e.hlt = (op == HLT) && (ph == 4);
    return e;
  endfunction

  task automatic advance();
    if (rst) begin
      m_ph = 0;
      m_hltd = 1'b0;
    end else if (m_hltd) begin
`ifdef CONTROL_SEQ_RESUME_EN
      if (resume) begin
        m_hltd = 1'b0;
        m_ph = 0;
      end
`endif
    end else begin
      if (m_ph == 4 && opcode == HLT) m_hltd = 1'b1;
      m_ph = (m_ph + 1) % 8;
    end
  endtask

  task automatic tick(input logic r, input opcode_t op,
                      input logic z, input logic res);
    @(posedge clk);
    #1;
    advance();
    rst = r;
    opcode = op;
    zero = z;
    resume = res;
    if (r) begin
      m_ph = 0;
      m_hltd = 1'b0;
    end
    q.push_back(expect_now(m_ph, m_hltd, opcode, zero));
  endtask

  task automatic mid_reset(input opcode_t op);
    @(posedge clk);
    #1;
    advance();
    opcode = op;
    zero = 1'($urandom % 2);
    #1;
    rst = 1'b1;
    m_ph = 0;
    m_hltd = 1'b0;
    q.push_back(expect_now(m_ph, m_hltd, opcode, zero));
  endtask

  task automatic run_instr(input opcode_t op, input int zm);
    logic z;
    for (int i = 0; i < 8; i++) begin
      z = (zm == 2) ? 1'($urandom % 2) : 1'(zm);
      tick(1'b0, op, z, 1'b0);
    end
  endtask

  task automatic rand_instr();
    opcode_t op;
    op = opcode_t'($urandom_range(1, 7));
    for (int i = 0; i < 8; i++)
      tick(1'b0, op, 1'($urandom % 2), 1'($urandom % 2));
  endtask

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h",
               nm, $time, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs with the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("phase",   8'(phase),   8'(e.ph));
      chk("halted",  8'(halted),  8'(e.hltd));
      chk("halt",    8'(halt),    8'(e.hlt));
      chk("mem_rd",  8'(mem_rd),  8'(e.rd));
      chk("mem_wr",  8'(mem_wr),  8'(e.wr));
      chk("load_ir", 8'(load_ir), 8'(e.ir));
      chk("load_ac", 8'(load_ac), 8'(e.ac));
      chk("load_pc", 8'(load_pc), 8'(e.lpc));
      chk("inc_pc",  8'(inc_pc),  8'(e.ipc));
    end
  end

  always @(posedge clk) begin
    if (!rst)
      assert (!$isunknown(opcode))
        else $error("opcode is X");
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    tick(1'b1, ADD, 1'b0, 1'b0);
    tick(1'b1, ADD, 1'b0, 1'b0);
    run_instr(ADD, 2);
    run_instr(ADD, 2);
    run_instr(STO, 2);
    run_instr(SKZ, 1);
    run_instr(SKZ, 0);
    run_instr(JMP, 2);
    for (int n = 0; n < 30; n++) rand_instr();
    for (int i = 0; i < 6; i++)
      tick(1'b0, LDA, 1'($urandom % 2), 1'b0);
    mid_reset(LDA);
    tick(1'b1, LDA, 1'b0, 1'b0);
    run_instr(LDA, 2);
    run_instr(XOR, 2);
    run_instr(HLT, 2);
    for (int i = 0; i < 22; i++)
      tick(1'b0, opcode_t'($urandom_range(0, 7)),
           1'($urandom % 2), 1'b0);
`ifdef CONTROL_SEQ_RESUME_EN
    tick(1'b0, ADD, 1'b0, 1'b1);
    run_instr(ADD, 2);
    run_instr(JMP, 2);
    for (int n = 0; n < 10; n++) rand_instr();
`endif
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("drain", 8'(q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_seq.md
# control_seq

Eight-phase instruction sequencer for the VeriRISC core. It produces the opcode-driven control strobes that move an instruction through fetch, decode and execute. It consumes the opcode held in the instruction register and the `zero` flag from the ALU, and drives memory, PC, IR and accumulator enables. It runs on the rising edge of `clk`; the ALU updates on the falling edge, so ALU results are stable by the next rising edge.

## Interface
- No parameters; widths are fixed by `typedefs::opcode_t` (3-bit).
- `clk`  in  1  system clock, rising-edge active
- `rst`  in  1  asynchronous, active-high reset
- `opcode`  in  `opcode_t`  current instruction opcode; HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7
- `zero`  in  1  ALU accumulator-zero flag
- `mem_rd`  out  1  memory read enable
- `mem_wr`  out  1  memory write enable
- `load_ir`  out  1  instruction register load
- `load_ac`  out  1  accumulator load
- `load_pc`  out  1  program counter load (jump)
- `inc_pc`  out  1  program counter increment
- `halt`  out  1  one-cycle pulse when HLT executes
- `halted`  out  1  sequencer stopped
- `phase`  out  3  current phase, 0..7

## Operation
- Phase register encoding: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
- The phase register advances by one each cycle and wraps from 7 to 0.
- `halted` register:
  - Set on the edge that leaves OP_ADDR when `opcode==HLT`.
  - While it is set, the phase holds at OP_FETCH (5) and all strobes are 0.
- Define ALUOP = opcode ∈ {ADD, AND, XOR, LDA}.
- Strobes are decoded combinationally from `phase`, `opcode` and `zero`, and are gated to 0 when `halted=1`:
  - INST_ADDR: all strobes 0.
  - INST_FETCH: `mem_rd`=1.
  - INST_LOAD: `mem_rd`=1, `load_ir`=1.
  - IDLE: `mem_rd`=1, `load_ir`=1.
  - OP_ADDR: `inc_pc`=1; `halt`=(opcode==HLT).
  - OP_FETCH: `mem_rd`=ALUOP.
  - ALU_OP:
    - `mem_rd`=ALUOP.
    - `load_ac`=ALUOP.
    - `inc_pc`=(opcode==SKZ && zero).
    - `load_pc`=(opcode==JMP).
  - STORE:
    - `mem_rd`=ALUOP.
    - `load_ac`=ALUOP.
    - `inc_pc`=(opcode==JMP).
    - `load_pc`=(opcode==JMP).
    - `mem_wr`=(opcode==STO).
- `opcode` is don't-care in phases 0–1. It must be stable from phase 3 through 7.
- `zero` is sampled only in ALU_OP. It reflects the accumulator before the current instruction.
- Out-of-range opcodes cannot occur (3-bit enum). A unique decode is required, and an X on `opcode` is a bench assertion failure.

## Timing
- Reset (async assert) forces:
  - `phase`=0 and `halted`=0.
  - All strobes 0, `halt`=0.
- Reset release: first rising edge moves to phase 1. Phase 0 lasts exactly one cycle after reset release.
- Instruction latency: 8 clocks per instruction; no stalls.
- `halt` is high for exactly the OP_ADDR cycle. `halted` rises at the next edge, with `phase`=5.
- Reset asserted mid-instruction: all outputs drop to 0 immediately, without waiting for a clock. The sequencer restarts at phase 0, and any partial write or PC update is abandoned.
- SKZ with `zero=1` produces two `inc_pc` pulses: one in OP_ADDR and one in ALU_OP. Net effect is skipping the next instruction.
- JMP produces `load_pc` in ALU_OP and again in STORE, plus `inc_pc` in STORE. The PC block gives `load_pc` priority over `inc_pc`.

## Configuration
- Macro: `CONTROL_SEQ_RESUME_EN`.
- Defined:
  - Adds input port `resume` (1 bit).
  - While `halted=1`, `resume=1` sampled on a rising edge clears `halted` and sets `phase`=0 (INST_ADDR). The next instruction is then fetched from the already-incremented PC.
  - `resume` is ignored when the sequencer is not halted.
- Undefined:
  - The port is absent.
  - `halted` is sticky until `rst`.

## Test plan
- Reset then ADD held on `opcode` → `phase` runs 0..7 and wraps. `load_ac` is high in phases 6–7 only, `mem_rd` is high in 1–3 and 5–7, and `inc_pc` is high in phase 4 only.
- STO → `mem_wr`=1 only in phase 7, and `mem_rd`=0 in phases 5–7.
- SKZ with `zero=1`, then SKZ with `zero=0` → `inc_pc` in phases 4 and 6 for the first instruction, and in phase 4 only for the second.
- JMP → `load_pc` high in phases 6 and 7, `inc_pc` high in 4 and 7, `load_ac`=0 throughout.
- HLT → `halt` pulses in phase 4. `halted`=1 from the next edge with `phase`=5, and all strobes stay 0 for at least 20 cycles. With `CONTROL_SEQ_RESUME_EN`, a `resume` pulse gives `phase`=0 and then normal fetch.
- `rst` asserted mid-cycle during phase 6 with LDA → outputs go to 0 before the next edge. After release, phase 0 is held for one cycle and then the sequence continues 1, 2, …
